// File: rtl/uart_pkg.sv
// Shared UART constants and the arbiter state encoding.
package uart_pkg;

  localparam int CLK_FREQ_HZ = 50_000_000;
  localparam int BAUD_DIV    = 434;
  localparam int FRAME_BITS  = 10;

  // IDLE: free to arbitrate; LAUNCH: trigger held until busy rises;
  // SEND: waiting for busy to fall; GAP: forced idle time before re-arbitration.
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_LAUNCH = 2'd1,
    ARB_SEND   = 2'd2,
    ARB_GAP    = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first set request at or after ptr,
// wrapping modulo N. Returns a one-hot grant, its index and an any flag.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id,
  output logic            any
);

  // Scan upward from the pointer; the first hit wins and later hits are ignored.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    for (int o = 0; o < N; o++) begin
      if (!any && req[(int'(ptr) + o) % N]) begin
        any                          = 1'b1;
        grant[(int'(ptr) + o) % N]   = 1'b1;
        grant_id                     = ID_W'((int'(ptr) + o) % N);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NUM_REQ byte sources. One byte per grant,
// round-robin order, one frame in flight at a time, launch timeout abort.
//
// Handshakes: a source raises req[i] with req_data byte i stable and keeps
// both until ack[i] pulses for one cycle (the byte is latched at that edge);
// it may change or drop them from the next cycle. done[i] pulses once when
// that byte's frame ends (tx_busy sampled low after it was seen high).
// Toward uart_tx, tx_trigger is held with tx_data stable until tx_busy is
// sampled high; the byte is dropped with err_timeout if that never happens.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int  NUM_REQ        = 4,
  parameter int  GAP_CYCLES     = 0,
  parameter int  LAUNCH_TIMEOUT = 1024,
  localparam int ID_W           = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   done,
  output logic                 tx_trigger,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [ID_W-1:0]      active_id,
  output logic                 err_timeout,
  output arb_state_t           fsm_state
);

  localparam int CNT_MAX     = (LAUNCH_TIMEOUT > GAP_CYCLES) ? LAUNCH_TIMEOUT : GAP_CYCLES;
  localparam int CNT_W       = $clog2(CNT_MAX + 1);
  localparam int LAUNCH_LAST = (LAUNCH_TIMEOUT > 0) ? LAUNCH_TIMEOUT - 1 : 0;
  localparam int GAP_LAST    = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  arb_state_t           state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [ID_W-1:0]      ptr, ptr_n;
  logic [NUM_REQ-1:0]   ack_n, done_n;
  logic                 trig_n, err_n;
  logic [7:0]           data_n;
  logic [ID_W-1:0]      id_n;

  logic [NUM_REQ-1:0]   grant;
  logic [ID_W-1:0]      grant_id;
  logic                 grant_any;

  rr_arbiter #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_rr (
    .req      (req),
    .ptr      (ptr),
    .grant    (grant),
    .grant_id (grant_id),
    .any      (grant_any)
  );

  assign fsm_state = state;

  // Next-state and next-output logic; pulses default low, held outputs default to their current value.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ptr_n   = ptr;
    ack_n   = '0;
    done_n  = '0;
    err_n   = 1'b0;
    trig_n  = tx_trigger;
    data_n  = tx_data;
    id_n    = active_id;
    case (state)
      ARB_IDLE: begin
        // A busy line here means a frame is still running from before a reset.
        if (!tx_busy && grant_any) begin
          ack_n   = grant;
          trig_n  = 1'b1;
          data_n  = req_data[8*grant_id +: 8];
          id_n    = grant_id;
          ptr_n   = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
          cnt_n   = '0;
          state_n = ARB_LAUNCH;
        end
      end
      ARB_LAUNCH: begin
        if (tx_busy) begin
          trig_n  = 1'b0;
          state_n = ARB_SEND;
        end else if (cnt == CNT_W'(LAUNCH_LAST)) begin
          trig_n  = 1'b0;
          err_n   = 1'b1;
          state_n = ARB_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ARB_SEND: begin
        if (!tx_busy) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            done_n[i] = (active_id == ID_W'(i));
          end
          cnt_n   = '0;
          state_n = (GAP_CYCLES > 0) ? ARB_GAP : ARB_IDLE;
        end
      end
      ARB_GAP: begin
        if (cnt == CNT_W'(GAP_LAST)) begin
          state_n = ARB_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = ARB_IDLE;
      end
    endcase
  end

  // State, counters and all outputs registered; reset clears everything, even mid-frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ARB_IDLE;
      cnt         <= '0;
      ptr         <= '0;
      ack         <= '0;
      done        <= '0;
      tx_trigger  <= 1'b0;
      tx_data     <= 8'h00;
      active_id   <= '0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      ptr         <= ptr_n;
      ack         <= ack_n;
      done        <= done_n;
      tx_trigger  <= trig_n;
      tx_data     <= data_n;
      active_id   <= id_n;
      err_timeout <= err_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queued byte sources, a behavioural uart_tx busy
// model, and a cycle-timestamp reference model checked every cycle.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int GAP     = 5;
  localparam int TMO     = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NUM_REQ-1:0]   req = '0;
  logic [NUM_REQ*8-1:0] req_data = '0;
  logic                 tx_busy = 1'b0;
  logic [NUM_REQ-1:0]   ack, done;
  logic                 tx_trigger, err_timeout;
  logic [7:0]           tx_data;
  logic [ID_W-1:0]      active_id;
  arb_state_t           fsm_state;

  uart_tx_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .GAP_CYCLES     (GAP),
    .LAUNCH_TIMEOUT (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .done        (done),
    .tx_trigger  (tx_trigger),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .active_id   (active_id),
    .err_timeout (err_timeout),
    .fsm_state   (fsm_state)
  );

  // ---------------- clock / cycle count ----------------
  always #10 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];          // {id, byte} of granted frames awaiting the line
  logic [7:0]  src_q[NUM_REQ][$]; // bytes each source still has to send
  int          ack_log[$];        // requester index of every observed ack
  int          n_done_seen = 0;
  int          n_err_seen  = 0;
  int          last_done_cyc = -1;
  int          last_gap = -1;
  bit          dead = 1'b0;       // busy model ignores triggers
  int          len_min = 4;
  int          len_max = 12;

  // reference model state (timestamp based)
  bit          m_inflight = 1'b0;
  bit          m_rose = 1'b0;
  int          m_launch = 0;
  int          m_free_at = 0;
  int          m_ptr = 0;
  int          m_id = 0;
  logic [7:0]  m_byte = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: cycle budget expired at cycle %0d", name, cyc);
  endtask

  // ---------------- source driver ----------------
  initial begin : driver
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (ack[i] === 1'b1) begin
          ack_log.push_back(i);
          if (src_q[i].size() > 0) void'(src_q[i].pop_front());
        end
        if (src_q[i].size() > 0) begin
          req[i]            = 1'b1;
          req_data[i*8 +: 8] = src_q[i][0];
        end else begin
          req[i] = 1'b0;
        end
      end
    end
  end

  // ---------------- uart_tx busy model ----------------
  initial begin : uart_model
    int d;
    int len;
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (tx_trigger === 1'b1 && !dead && !tx_busy) begin
        d   = $urandom_range(1, 3);
        len = $urandom_range(len_min, len_max);
        repeat (d) @(posedge clk);
        #1;
        tx_busy = 1'b1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_unexpected at cycle %0d: byte 0x%0h with no granted request", cyc, tx_data);
        end else begin
          e = exp_q.pop_front();
          check("frame_byte", 32'(tx_data), 32'(e[7:0]));
        end
        repeat (len) @(posedge clk);
        #1;
        tx_busy = 1'b0;
      end
    end
  end

  // ---------------- monitor / reference model ----------------
  initial begin : monitor
    logic                 s_rst, s_busy;
    logic [NUM_REQ-1:0]   s_req;
    logic [NUM_REQ*8-1:0] s_data;
    logic [NUM_REQ-1:0]   e_ack, e_done;
    logic                 e_err, e_trig;
    bit                   primed, chk_data, chk_id, found;
    int                   win, j;
    primed = 1'b0;
    s_rst = 1'b1; s_busy = 1'b0; s_req = '0; s_data = '0;
    forever begin
      @(negedge clk);
      if (primed) begin
        e_ack = '0; e_done = '0; e_err = 1'b0; e_trig = 1'b0;
        chk_data = 1'b0; chk_id = 1'b0;
        if (s_rst) begin
          m_inflight = 1'b0;
          m_free_at  = cyc + 1;
          m_ptr      = 0;
          last_done_cyc = -1;
          exp_q.delete();
          check("rst_tx_data", 32'(tx_data), 32'd0);
          check("rst_active_id", 32'(active_id), 32'd0);
        end else if (m_inflight) begin
          if (!m_rose) begin
            if (s_busy) begin
              m_rose = 1'b1;
              chk_id = 1'b1;
            end else if (cyc - m_launch >= TMO) begin
              e_err      = 1'b1;
              m_inflight = 1'b0;
              m_free_at  = cyc + 1;
              if (exp_q.size() > 0) void'(exp_q.pop_back());
            end else begin
              e_trig   = 1'b1;
              chk_data = 1'b1;
            end
          end else begin
            chk_id = 1'b1;
            if (!s_busy) begin
              e_done[m_id] = 1'b1;
              m_inflight   = 1'b0;
              m_free_at    = cyc + GAP + 1;
            end
          end
        end else if (cyc >= m_free_at && !s_busy && s_req != '0) begin
          found = 1'b0;
          win = 0;
          for (int o = 0; o < NUM_REQ; o++) begin
            j = (m_ptr + o) % NUM_REQ;
            if (!found && s_req[j]) begin
              found = 1'b1;
              win = j;
            end
          end
          e_ack[win] = 1'b1;
          e_trig     = 1'b1;
          chk_data   = 1'b1;
          m_id       = win;
          m_byte     = s_data[win*8 +: 8];
          m_ptr      = (win + 1) % NUM_REQ;
          m_inflight = 1'b1;
          m_rose     = 1'b0;
          m_launch   = cyc;
          exp_q.push_back({8'(win), m_byte});
        end
        check("ack", 32'(ack), 32'(e_ack));
        check("done", 32'(done), 32'(e_done));
        check("err_timeout", 32'(err_timeout), 32'(e_err));
        check("tx_trigger", 32'(tx_trigger), 32'(e_trig));
        if (chk_data) check("tx_data", 32'(tx_data), 32'(m_byte));
        if (chk_data || chk_id) check("active_id", 32'(active_id), 32'(m_id));
        // observed-event counters for the directed scenarios
        if (err_timeout === 1'b1) n_err_seen++;
        if (ack != '0 && last_done_cyc >= 0) begin
          last_gap = cyc - last_done_cyc;
          last_done_cyc = -1;
        end
        if (done != '0) begin
          n_done_seen++;
          last_done_cyc = cyc;
        end
      end
      s_rst  = rst;
      s_busy = tx_busy;
      s_req  = req;
      s_data = req_data;
      primed = 1'b1;
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic bit all_sources_empty();
    for (int i = 0; i < NUM_REQ; i++) if (src_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (all_sources_empty() && !m_inflight && !tx_busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail(name);
    repeat (GAP + 2) @(posedge clk);
  endtask

  task automatic pulse_rst();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic check_ack_seq(input string name, input int base, input int n, input int seq[$]);
    if (ack_log.size() < base + n) begin
      check({name, "_count"}, 32'(ack_log.size() - base), 32'(n));
    end else begin
      for (int k = 0; k < n; k++) check(name, 32'(ack_log[base + k]), 32'(seq[k]));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int base, d0, e0;
    int seq[$];
    bit seen;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // single request from source 0
    base = ack_log.size();
    @(posedge clk); #2;
    src_q[0].push_back(8'h41);
    wait_idle(300, "wait_single");
    seq = '{0};
    check_ack_seq("single_ack", base, 1, seq);

    // all four at once, starting from a reset pointer
    pulse_rst();
    base = ack_log.size();
    @(posedge clk); #2;
    src_q[0].push_back(8'h41);
    src_q[1].push_back(8'h35);
    src_q[2].push_back(8'h0D);
    src_q[3].push_back(8'h0A);
    wait_idle(800, "wait_all_four");
    seq = '{0, 1, 2, 3};
    check_ack_seq("all_four_order", base, 4, seq);

    // sources 0 and 2 continuously pending: grants alternate across the wrap
    base = ack_log.size();
    @(posedge clk); #2;
    for (int k = 0; k < 6; k++) begin
      src_q[0].push_back(8'($urandom_range(0, 255)));
      src_q[2].push_back(8'($urandom_range(0, 255)));
    end
    wait_idle(2000, "wait_alternate");
    seq = '{0, 2, 0, 2, 0, 2, 0, 2, 0, 2, 0, 2};
    check_ack_seq("alternate_order", base, 12, seq);

    // busy never rises: launch aborts after the timeout, then service resumes
    dead = 1'b1;
    e0 = n_err_seen;
    d0 = n_done_seen;
    @(posedge clk); #2;
    src_q[1].push_back(8'h55);
    wait_idle(200, "wait_timeout");
    check("timeout_pulses", 32'(n_err_seen - e0), 32'd1);
    check("timeout_no_done", 32'(n_done_seen - d0), 32'd0);
    dead = 1'b0;
    base = ack_log.size();
    d0 = n_done_seen;
    @(posedge clk); #2;
    src_q[1].push_back(8'h66);
    wait_idle(300, "wait_after_timeout");
    seq = '{1};
    check_ack_seq("after_timeout_ack", base, 1, seq);
    check("after_timeout_done", 32'(n_done_seen - d0), 32'd1);

    // reset in the middle of a frame while another source is pending
    len_min = 20;
    len_max = 20;
    base = ack_log.size();
    d0 = n_done_seen;
    @(posedge clk); #2;
    src_q[3].push_back(8'h77);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx_busy) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) timeout_fail("wait_busy_rise");
    @(posedge clk); #2;
    src_q[1].push_back(8'h12);
    pulse_rst();
    wait_idle(400, "wait_mid_reset");
    seq = '{3, 1};
    check_ack_seq("mid_reset_order", base, 2, seq);
    check("mid_reset_done", 32'(n_done_seen - d0), 32'd1);
    len_min = 4;
    len_max = 12;

    // back-to-back requests: next trigger GAP+1 cycles after busy sampled low
    last_gap = -1;
    @(posedge clk); #2;
    src_q[2].push_back(8'hA5);
    src_q[3].push_back(8'h5A);
    wait_idle(400, "wait_gap");
    check("gap_cycles", 32'(last_gap), 32'(GAP + 1));

    // randomized traffic
    len_min = 2;
    for (int r = 0; r < 40; r++) begin
      @(posedge clk); #2;
      for (int i = 0; i < NUM_REQ; i++) begin
        if ($urandom_range(0, 1) == 1) src_q[i].push_back(8'($urandom_range(0, 255)));
      end
      repeat ($urandom_range(0, 30)) @(posedge clk);
    end
    wait_idle(8000, "wait_random");

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // global safety net
  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_tx transmitter (trigger/data_in/busy interface, 8N1, BAUD_DIV=434 at 50 MHz) between NUM_REQ byte sources. Grants round-robin, launches one byte per grant and waits for the frame to finish. Reports per-requester accept and completion, plus a launch timeout. Sits between the byte producers (command responder, status logger, debug echo) and uart_tx.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
GAP_CYCLES, 0, idle clock cycles forced between end of one frame (busy fall) and next trigger
LAUNCH_TIMEOUT, 1024, max cycles trigger is held waiting for busy to rise before abort
ID_W, $clog2(NUM_REQ), localparam; width of requester index

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  synchronous reset, active-high
req  in  NUM_REQ  per-requester byte-pending request; hold with data stable until ack
req_data  in  NUM_REQ*8  packed bytes; requester i at bits [8i+7:8i]
ack  out  NUM_REQ  one-cycle pulse: byte of requester i latched
done  out  NUM_REQ  one-cycle pulse: frame of requester i completed (busy fell)
tx_trigger  out  1  to uart_tx trigger
tx_data  out  8  to uart_tx data_in
tx_busy  in  1  from uart_tx busy
active_id  out  ID_W  index of current owner, valid while state != IDLE
err_timeout  out  1  one-cycle pulse: launch aborted

Behaviour:
- Reset (sync, rst=1 at clk edge): state=IDLE, ack=0, done=0, tx_trigger=0, tx_data=0, active_id=0, err_timeout=0, rr pointer=0, counters=0. Applies mid-frame. uart_tx is not reset by this block; IDLE guard below prevents overlap.
- All outputs registered.
- States: IDLE, LAUNCH, SEND, GAP.
- IDLE: if tx_busy=0 and |req, select winner = first set req at or after rr pointer, wrapping modulo NUM_REQ. Next edge: ack[winner]=1 (one cycle), tx_data=req_data[winner], tx_trigger=1, active_id=winner, rr pointer=winner+1 mod NUM_REQ, state->LAUNCH. Latency req->ack/trigger: 1 cycle. If tx_busy=1, no grant.
- LAUNCH: tx_trigger and tx_data held. On tx_busy=1: tx_trigger=0, state->SEND. Cycle counter counts LAUNCH cycles. At LAUNCH_TIMEOUT cycles without busy: tx_trigger=0, err_timeout pulse, no done, state->IDLE. Byte is dropped (ack already given).
- SEND: on tx_busy 1->0 (sampled 0): done[active_id] pulse. State->GAP if GAP_CYCLES>0, else IDLE.
- GAP: count GAP_CYCLES cycles, then IDLE. Next trigger is no earlier than GAP_CYCLES+1 cycles after busy sampled low.
- A requester may drop req or present a new byte the cycle after ack. req changes outside IDLE are ignored until the next arbitration.
- Simultaneous requests: strict rotation. A continuously requesting source waits at most NUM_REQ-1 frames.
- ack and done never assert for more than one requester in a cycle. At most one frame is in flight.

Decomposition:
- Shared package uart_pkg: CLK_FREQ_HZ=50_000_000, BAUD_DIV=434, FRAME_BITS=10, state encoding constants for this block.
- One sub-module: rr_arbiter (combinational; inputs req vector and pointer; output one-hot grant plus index). Reused by later multi-source blocks.
- The FSM, counters and registers stay in uart_tx_arbiter.

Test Plan:
- Single request: req[0]=1, req_data[7:0]=0x41 -> ack[0] one cycle later; tx_trigger=1 with tx_data=0x41 until busy rises; tx line frames 0x41; done[0] after about 4340 cycles.
- All four request in the same cycle with 0x41,0x35,0x0D,0x0A -> acks in order 0,1,2,3; four non-overlapping frames; tx carries 0x41,0x35,0x0D,0x0A.
- req0 and req2 held high continuously -> grants alternate 0,2,0,2; rr pointer wraps from 3 to 0 correctly.
- Busy model tied 0, LAUNCH_TIMEOUT=16 -> tx_trigger high exactly 16 cycles; err_timeout one pulse; no done; next request is granted afterwards.
- rst=1 for one cycle during SEND while uart_tx keeps busy=1, req[1] pending -> all outputs 0 on the next edge; no ack[1] until busy falls; then ack[1] follows.
- GAP_CYCLES=5, two back-to-back requests -> second tx_trigger rises exactly 6 cycles after busy is sampled low.
